// File: rtl/reg_wb_sched.sv
// rtl/reg_wb_sched.sv - write-back arbiter and RAW/WAW hazard scoreboard for the register file
// Optional: define WB_RR_EN for round-robin arbitration; default is fixed priority LSU > MDU > EXU.
module reg_wb_sched #(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              issue_valid,
  input  logic              issue_wen,
  input  logic [4:0]        issue_rd,
  input  logic [4:0]        issue_rs1,
  input  logic [4:0]        issue_rs2,
  output logic              issue_ready,
  input  logic              exu_valid,
  input  logic [4:0]        exu_rd,
  input  logic [DATA_W-1:0] exu_data,
  output logic              exu_ready,
  input  logic              lsu_valid,
  input  logic [4:0]        lsu_rd,
  input  logic [DATA_W-1:0] lsu_data,
  output logic              lsu_ready,
  input  logic              mdu_valid,
  input  logic [4:0]        mdu_rd,
  input  logic [DATA_W-1:0] mdu_data,
  output logic              mdu_ready,
  output logic              write_reg,
  output logic [4:0]        target_reg,
  output logic [DATA_W-1:0] write_rd_data,
  output logic [31:0]       busy_mask,
  output logic              wb_err
);

  logic [31:0]       busy;
  logic [31:0]       busy_nxt;
  logic [2:0]        req;
  logic [2:0]        gnt;
  logic              gnt_any;
  logic [4:0]        gnt_rd;
  logic [DATA_W-1:0] gnt_data;
  logic              issue_fire;

  assign req = {mdu_valid, lsu_valid, exu_valid};

`ifdef WB_RR_EN
  // rr_ptr is the first source searched: 0=EXU, 1=LSU, 2=MDU
  logic [1:0] rr_ptr;

  always_comb begin
    gnt = 3'b000;
    case (rr_ptr)
      2'd1: begin
        if (req[1])      gnt = 3'b010;
        else if (req[2]) gnt = 3'b100;
        else if (req[0]) gnt = 3'b001;
      end
      2'd2: begin
        if (req[2])      gnt = 3'b100;
        else if (req[0]) gnt = 3'b001;
        else if (req[1]) gnt = 3'b010;
      end
      default: begin
        if (req[0])      gnt = 3'b001;
        else if (req[1]) gnt = 3'b010;
        else if (req[2]) gnt = 3'b100;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_ptr <= 2'd0;
    end else if (gnt[0]) begin
      rr_ptr <= 2'd1;
    end else if (gnt[1]) begin
      rr_ptr <= 2'd2;
    end else if (gnt[2]) begin
      rr_ptr <= 2'd0;
    end
  end
`else
  always_comb begin
    gnt = 3'b000;
    if (req[1])      gnt = 3'b010;
    else if (req[2]) gnt = 3'b100;
    else if (req[0]) gnt = 3'b001;
  end
`endif

  assign exu_ready = gnt[0];
  assign lsu_ready = gnt[1];
  assign mdu_ready = gnt[2];
  assign gnt_any   = |gnt;

  always_comb begin
    gnt_rd   = 5'd0;
    gnt_data = '0;
    if (gnt[0]) begin
      gnt_rd   = exu_rd;
      gnt_data = exu_data;
    end else if (gnt[1]) begin
      gnt_rd   = lsu_rd;
      gnt_data = lsu_data;
    end else if (gnt[2]) begin
      gnt_rd   = mdu_rd;
      gnt_data = mdu_data;
    end
  end

  // Bit 0 of busy is held at zero, so index 0 never reports a hazard.
  assign issue_ready = !(busy[issue_rs1] || busy[issue_rs2] ||
                         (issue_wen && busy[issue_rd]));
  assign issue_fire  = issue_valid && issue_ready;

  // WAW stalls guarantee the set and clear below never hit the same bit.
  always_comb begin
    busy_nxt = busy;
    if (write_reg) busy_nxt[target_reg] = 1'b0;
    if (issue_fire && issue_wen && (issue_rd != 5'd0)) busy_nxt[issue_rd] = 1'b1;
    busy_nxt[0] = 1'b0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy <= 32'd0;
    end else begin
      busy <= busy_nxt;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      write_reg     <= 1'b0;
      target_reg    <= 5'd0;
      write_rd_data <= '0;
    end else begin
      write_reg <= gnt_any && (gnt_rd != 5'd0);
      if (gnt_any) begin
        target_reg    <= gnt_rd;
        write_rd_data <= gnt_data;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wb_err <= 1'b0;
    end else if (gnt_any && (gnt_rd != 5'd0) && !busy[gnt_rd]) begin
      wb_err <= 1'b1;
    end
  end

  assign busy_mask = busy;

endmodule

// File: tb/tb_reg_wb_sched.sv
// tb/tb_reg_wb_sched.sv - scoreboard bench for reg_wb_sched
module tb_reg_wb_sched;

  logic        clk;
  logic        rst;
  logic        issue_valid, issue_wen;
  logic [4:0]  issue_rd, issue_rs1, issue_rs2;
  logic        issue_ready;
  logic        exu_valid, lsu_valid, mdu_valid;
  logic [4:0]  exu_rd, lsu_rd, mdu_rd;
  logic [31:0] exu_data, lsu_data, mdu_data;
  logic        exu_ready, lsu_ready, mdu_ready;
  logic        write_reg;
  logic [4:0]  target_reg;
  logic [31:0] write_rd_data;
  logic [31:0] busy_mask;
  logic        wb_err;

  int checks = 0;
  int errors = 0;
  logic [36:0] exp_q[$];
  int order[3];

  reg_wb_sched #(.DATA_W(32)) dut (
    .clk(clk), .rst(rst),
    .issue_valid(issue_valid), .issue_wen(issue_wen), .issue_rd(issue_rd),
    .issue_rs1(issue_rs1), .issue_rs2(issue_rs2), .issue_ready(issue_ready),
    .exu_valid(exu_valid), .exu_rd(exu_rd), .exu_data(exu_data), .exu_ready(exu_ready),
    .lsu_valid(lsu_valid), .lsu_rd(lsu_rd), .lsu_data(lsu_data), .lsu_ready(lsu_ready),
    .mdu_valid(mdu_valid), .mdu_rd(mdu_rd), .mdu_data(mdu_data), .mdu_ready(mdu_ready),
    .write_reg(write_reg), .target_reg(target_reg), .write_rd_data(write_rd_data),
    .busy_mask(busy_mask), .wb_err(wb_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [36:0] act, input logic [36:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic settle_chk_ready(input string name, input logic [2:0] exp);
    #1;
    chk(name, {34'd0, mdu_ready, lsu_ready, exu_ready}, {34'd0, exp});
  endtask

  // Monitor: every register-file write must match the next queued expectation.
  always @(negedge clk) begin
    if (!rst && write_reg) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_write", {target_reg, write_rd_data}, 37'd0);
      end else begin
        chk("wb_write", {target_reg, write_rd_data}, exp_q.pop_front());
      end
    end
  end

  initial begin
`ifdef WB_RR_EN
    order = '{0, 1, 2};
`else
    order = '{1, 2, 0};
`endif
    rst = 1'b0;
    issue_valid = 0; issue_wen = 0; issue_rd = 0; issue_rs1 = 0; issue_rs2 = 0;
    exu_valid = 0; exu_rd = 0; exu_data = 0;
    lsu_valid = 0; lsu_rd = 0; lsu_data = 0;
    mdu_valid = 0; mdu_rd = 0; mdu_data = 0;
    #1 rst = 1'b1;
    step();
    chk("rst_busy", {5'd0, busy_mask}, 37'd0);
    chk("rst_write_reg", {36'd0, write_reg}, 37'd0);
    chk("rst_target", {target_reg, write_rd_data}, 37'd0);
    chk("rst_wb_err", {36'd0, wb_err}, 37'd0);
    chk("rst_issue_ready", {36'd0, issue_ready}, 37'd1);
    settle_chk_ready("rst_src_ready", 3'b000);
    step();
    rst = 1'b0;

    // Three-way contention with registers 1..3 busy
    for (int r = 1; r <= 3; r++) begin
      issue_valid = 1; issue_wen = 1; issue_rd = 5'(r);
      step();
    end
    issue_valid = 0; issue_wen = 0; issue_rd = 0;
    chk("cont_busy", {5'd0, busy_mask}, {5'd0, 32'h0000_000E});
    exu_valid = 1; exu_rd = 1; exu_data = 32'h11;
    lsu_valid = 1; lsu_rd = 2; lsu_data = 32'h22;
    mdu_valid = 1; mdu_rd = 3; mdu_data = 32'h33;
    for (int i = 0; i < 3; i++) begin
      settle_chk_ready($sformatf("cont_grant%0d", i), 3'(1 << order[i]));
      exp_q.push_back({5'(order[i] + 1), 32'h11 * (order[i] + 1)});
      step();
      case (order[i])
        0: exu_valid = 0;
        1: lsu_valid = 0;
        default: mdu_valid = 0;
      endcase
    end
    step();
    chk("cont_busy_clear", {5'd0, busy_mask}, 37'd0);
    chk("cont_wb_err", {36'd0, wb_err}, 37'd0);

    // RAW: rd=5 outstanding, consumer reads rs1=5
    issue_valid = 1; issue_wen = 1; issue_rd = 5;
    #1 chk("raw_issue_ok", {36'd0, issue_ready}, 37'd1);
    step();
    chk("raw_busy_set", {5'd0, busy_mask}, {5'd0, 32'h0000_0020});
    issue_wen = 0; issue_rd = 0; issue_rs1 = 5;
    #1 chk("raw_stall", {36'd0, issue_ready}, 37'd0);
    exu_valid = 1; exu_rd = 5; exu_data = 32'hDEADBEEF;
    settle_chk_ready("raw_exu_grant", 3'b001);
    chk("raw_stall_n", {36'd0, issue_ready}, 37'd0);
    exp_q.push_back({5'd5, 32'hDEADBEEF});
    step();
    exu_valid = 0;
    chk("raw_wr_n1", {31'd0, write_reg, target_reg}, {31'd0, 1'b1, 5'd5});
    chk("raw_stall_n1", {36'd0, issue_ready}, 37'd0);
    chk("raw_busy_n1", {5'd0, busy_mask}, {5'd0, 32'h0000_0020});
    step();
    chk("raw_busy_n2", {5'd0, busy_mask}, 37'd0);
    chk("raw_ready_n2", {36'd0, issue_ready}, 37'd1);
    chk("raw_wr_n2", {36'd0, write_reg}, 37'd0);
    issue_valid = 0; issue_rs1 = 0;

    // WAW: rd=7 outstanding, second writer to rd=7
    issue_valid = 1; issue_wen = 1; issue_rd = 7;
    step();
    issue_valid = 0;
    #1 chk("waw_stall", {36'd0, issue_ready}, 37'd0);
    issue_wen = 0;
    #1 chk("waw_no_wen_ok", {36'd0, issue_ready}, 37'd1);
    issue_wen = 1;
    lsu_valid = 1; lsu_rd = 7; lsu_data = 32'h77;
    settle_chk_ready("waw_lsu_grant", 3'b010);
    exp_q.push_back({5'd7, 32'h77});
    step();
    lsu_valid = 0;
    chk("waw_stall_n1", {36'd0, issue_ready}, 37'd0);
    step();
    chk("waw_ready_n2", {36'd0, issue_ready}, 37'd1);
    issue_wen = 0; issue_rd = 0;

    // Zero destination: no busy set, consumed without a write
    issue_valid = 1; issue_wen = 1; issue_rd = 0;
    step();
    issue_valid = 0; issue_wen = 0;
    chk("zero_busy", {5'd0, busy_mask}, 37'd0);
    lsu_valid = 1; lsu_rd = 0; lsu_data = 32'h1234;
    settle_chk_ready("zero_lsu_grant", 3'b010);
    step();
    lsu_valid = 0;
    chk("zero_no_write", {36'd0, write_reg}, 37'd0);
    chk("zero_outputs", {target_reg, write_rd_data}, {5'd0, 32'h1234});
    chk("zero_busy2", {5'd0, busy_mask}, 37'd0);
    chk("zero_wb_err", {36'd0, wb_err}, 37'd0);

    // Spurious write-back to non-busy rd=9
    mdu_valid = 1; mdu_rd = 9; mdu_data = 32'h99;
    settle_chk_ready("spur_mdu_grant", 3'b100);
    chk("spur_err_before", {36'd0, wb_err}, 37'd0);
    exp_q.push_back({5'd9, 32'h99});
    step();
    mdu_valid = 0;
    chk("spur_err_set", {36'd0, wb_err}, 37'd1);
    step();
    step();
    chk("spur_err_sticky", {36'd0, wb_err}, 37'd1);
    chk("spur_busy", {5'd0, busy_mask}, 37'd0);

    // Asynchronous reset with busy 3,4 and a write in flight
    issue_valid = 1; issue_wen = 1; issue_rd = 3;
    step();
    issue_rd = 4;
    step();
    issue_valid = 0; issue_wen = 0; issue_rd = 0;
    exu_valid = 1; exu_rd = 3; exu_data = 32'h3333;
    step();
    exu_valid = 0;
    chk("arst_pre_write", {36'd0, write_reg}, 37'd1);
    chk("arst_pre_busy", {5'd0, busy_mask}, {5'd0, 32'h0000_0018});
    #1 rst = 1'b1;
    #1;
    chk("arst_busy", {5'd0, busy_mask}, 37'd0);
    chk("arst_write_reg", {36'd0, write_reg}, 37'd0);
    chk("arst_wb_err", {36'd0, wb_err}, 37'd0);
    chk("arst_target", {target_reg, write_rd_data}, 37'd0);
    step();
    rst = 1'b0;
    step();

    chk("queue_drained", 37'(exp_q.size()), 37'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
